// File: rtl/zynet_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : zynet_cfg_sequencer
// Description : AXI4-Lite master that streams layer/neuron/weight/bias config
//               into a ZyNet core, then reads the class result on interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module zynet_cfg_sequencer #(
    parameter int                        NUM_LAYERS = 4,
    parameter int                        DATA_WIDTH = 16,
    parameter logic [32*NUM_LAYERS-1:0]  NEURON_TAB = {32'd10, 32'd10, 32'd30, 32'd30},
    parameter logic [32*NUM_LAYERS-1:0]  WEIGHT_TAB = {32'd10, 32'd30, 32'd30, 32'd784}
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [31:0]           m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [31:0]           m_wdata,
    output logic [3:0]            m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [31:0]           m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [31:0]           m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic                  intr,
    output logic                  busy,
    output logic                  cfg_done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid
);

    localparam int LW        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int TAB_DEPTH = 1 << LW;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_SRST   = 4'd1,
        S_LAYER  = 4'd2,
        S_NEURON = 4'd3,
        S_WEIGHT = 4'd4,
        S_BIAS   = 4'd5,
        S_WRESP  = 4'd6,
        S_RUN    = 4'd7,
        S_RADDR  = 4'd8,
        S_RDATA  = 4'd9
    } state_t;

    logic [31:0] neuron_tab [TAB_DEPTH];
    logic [31:0] weight_tab [TAB_DEPTH];

    // Power-of-two padded lookup so the layer counter indexes without range issues.
    for (genvar g = 0; g < TAB_DEPTH; g++) begin : g_tab
        if (g < NUM_LAYERS) begin : g_used
            assign neuron_tab[g] = NEURON_TAB[32*g +: 32];
            assign weight_tab[g] = WEIGHT_TAB[32*g +: 32];
        end else begin : g_pad
            assign neuron_tab[g] = 32'd1;
            assign weight_tab[g] = 32'd1;
        end
    end

    if (DATA_WIDTH < 32) begin : g_rdata_unused
        logic unused_rdata;
        assign unused_rdata = ^m_rdata[31:DATA_WIDTH];
    end

    state_t                state_q, state_d;
    state_t                ret_q, ret_d;
    logic                  issued_q, issued_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic [31:0]           awaddr_q, awaddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  arvalid_q, arvalid_d;
    logic [31:0]           araddr_q, araddr_d;
    logic [LW-1:0]         layer_q, layer_d;
    logic [31:0]           neuron_q, neuron_d;
    logic [31:0]           weight_q, weight_d;
    logic                  bias_q, bias_d;
    logic                  busy_q, busy_d;
    logic                  cfg_done_q, cfg_done_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  result_valid_q, result_valid_d;
    logic                  intr_q, intr_d;
    logic                  intr_prev_q, intr_prev_d;

    logic        wr_state, cfg_state, aw_done, w_done, intr_edge;
    logic        neuron_last, weight_last, layer_last;
    logic [31:0] wr_addr, wr_data;

    assign wr_state    = (state_q inside {S_SRST, S_LAYER, S_NEURON, S_WEIGHT, S_BIAS});
    assign cfg_state   = (state_q inside {S_WEIGHT, S_BIAS});
    assign aw_done     = !awvalid_q || m_awready;
    assign w_done      = !wvalid_q || m_wready;
    assign intr_edge   = intr_q && !intr_prev_q;
    assign neuron_last = (neuron_q == neuron_tab[layer_q] - 32'd1);
    assign weight_last = (weight_q == weight_tab[layer_q] - 32'd1);
    assign layer_last  = (layer_q == LW'(NUM_LAYERS - 1));

    always_comb begin
        wr_addr = 32'h0;
        wr_data = 32'h0;
        case (state_q)
            S_SRST:   begin wr_addr = 32'h1C; wr_data = 32'h0;                 end
            S_LAYER:  begin wr_addr = 32'h0C; wr_data = 32'(layer_q) + 32'd1;  end
            S_NEURON: begin wr_addr = 32'h10; wr_data = neuron_q;              end
            S_WEIGHT: begin wr_addr = 32'h00; wr_data = 32'(cfg_data);         end
            S_BIAS:   begin wr_addr = 32'h04; wr_data = 32'(cfg_data);         end
            default:  ;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        ret_d          = ret_q;
        issued_d       = issued_q;
        awvalid_d      = awvalid_q && !m_awready;
        wvalid_d       = wvalid_q && !m_wready;
        awaddr_d       = awaddr_q;
        wdata_d        = wdata_q;
        arvalid_d      = arvalid_q && !m_arready;
        araddr_d       = araddr_q;
        layer_d        = layer_q;
        neuron_d       = neuron_q;
        weight_d       = weight_q;
        bias_d         = bias_q;
        cfg_done_d     = cfg_done_q;
        err_d          = err_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        intr_d         = intr;
        intr_prev_d    = intr_q;

        // Every write state launches once, then waits for both address and data to land.
        if (wr_state) begin
            if (!issued_q) begin
                if (!cfg_state || cfg_valid) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = wr_addr;
                    wdata_d   = wr_data;
                    issued_d  = 1'b1;
                end
            end else if (aw_done && w_done) begin
                state_d  = S_WRESP;
                ret_d    = state_q;
                issued_d = 1'b0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SRST;
                    layer_d  = '0;
                    neuron_d = 32'd0;
                    weight_d = 32'd0;
                    bias_d   = 1'b0;
                end
            end
            S_WRESP: begin
                if (m_bvalid) begin
                    if (m_bresp != 2'b00) err_d = 1'b1;
                    case (ret_q)
                        S_SRST:   state_d = S_LAYER;
                        S_LAYER:  state_d = S_NEURON;
                        S_NEURON: state_d = bias_q ? S_BIAS : S_WEIGHT;
                        S_WEIGHT, S_BIAS: begin
                            if (ret_q == S_WEIGHT && !weight_last) begin
                                weight_d = weight_q + 32'd1;
                                state_d  = S_WEIGHT;
                            end else if (!neuron_last) begin
                                weight_d = 32'd0;
                                neuron_d = neuron_q + 32'd1;
                                state_d  = S_NEURON;
                            end else if (!layer_last) begin
                                weight_d = 32'd0;
                                neuron_d = 32'd0;
                                layer_d  = layer_q + 1'b1;
                                state_d  = S_LAYER;
                            end else begin
                                weight_d = 32'd0;
                                neuron_d = 32'd0;
                                layer_d  = '0;
                                if (!bias_q) begin
                                    bias_d  = 1'b1;
                                    state_d = S_LAYER;
                                end else begin
                                    cfg_done_d = 1'b1;
                                    state_d    = S_RUN;
                                end
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_RUN: begin
                if (intr_edge) begin
                    state_d   = S_RADDR;
                    arvalid_d = 1'b1;
                    araddr_d  = 32'h08;
                end
            end
            S_RADDR: begin
                if (m_arready) state_d = S_RDATA;
            end
            S_RDATA: begin
                if (m_rvalid) begin
                    if (m_rresp != 2'b00) err_d = 1'b1;
                    result_d       = m_rdata[DATA_WIDTH-1:0];
                    result_valid_d = 1'b1;
                    state_d        = S_RUN;
                end
            end
            default: ;
        endcase

        busy_d = !(state_d inside {S_IDLE, S_RUN, S_RADDR, S_RDATA});
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q        <= S_IDLE;
            ret_q          <= S_IDLE;
            issued_q       <= 1'b0;
            awvalid_q      <= 1'b0;
            wvalid_q       <= 1'b0;
            awaddr_q       <= 32'h0;
            wdata_q        <= 32'h0;
            arvalid_q      <= 1'b0;
            araddr_q       <= 32'h0;
            layer_q        <= '0;
            neuron_q       <= 32'd0;
            weight_q       <= 32'd0;
            bias_q         <= 1'b0;
            busy_q         <= 1'b0;
            cfg_done_q     <= 1'b0;
            err_q          <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            intr_q         <= 1'b0;
            intr_prev_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            ret_q          <= ret_d;
            issued_q       <= issued_d;
            awvalid_q      <= awvalid_d;
            wvalid_q       <= wvalid_d;
            awaddr_q       <= awaddr_d;
            wdata_q        <= wdata_d;
            arvalid_q      <= arvalid_d;
            araddr_q       <= araddr_d;
            layer_q        <= layer_d;
            neuron_q       <= neuron_d;
            weight_q       <= weight_d;
            bias_q         <= bias_d;
            busy_q         <= busy_d;
            cfg_done_q     <= cfg_done_d;
            err_q          <= err_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            intr_q         <= intr_d;
            intr_prev_q    <= intr_prev_d;
        end
    end

    assign cfg_ready    = cfg_state && !issued_q;
    assign m_awaddr     = awaddr_q;
    assign m_awvalid    = awvalid_q;
    assign m_wdata      = wdata_q;
    assign m_wstrb      = 4'hF;
    assign m_wvalid     = wvalid_q;
    assign m_bready     = (state_q == S_WRESP);
    assign m_araddr     = araddr_q;
    assign m_arvalid    = arvalid_q;
    assign m_rready     = (state_q == S_RDATA);
    assign busy         = busy_q;
    assign cfg_done     = cfg_done_q;
    assign err          = err_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule
`default_nettype wire
